flash_boot_loader: RTL and testbench
====================================

# flash_boot_loader

Boot-time copier sitting directly downstream of the SPI flash read controller and upstream of the CPU and its program RAM. After reset it holds the CPU in reset and issues WORD_COUNT sequential 32-bit word reads through the flash controller's request/valid interface. It writes each returned word into program RAM, then releases the CPU. A timeout guards every flash transaction, and an optional checksum validates the image before release.

## Interface
Parameters:
- WORD_COUNT, 1024 — number of 32-bit words copied; 1 ≤ WORD_COUNT ≤ 2^RAM_AW.
- START_ADDR, 16'h0000 — first flash word address presented on flash_adresse.
- RAM_AW, 10 — program RAM word-address width.
- TIMEOUT, 4096 — clk cycles allowed in each wait state before error; ≥ 2.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst  in  1  reset, asynchronous, active-high.
- flash_adresse  out  16  flash word address (controller forms byte address {addr,2'b00}).
- flash_read_enable  out  1  read request level; the controller acts on its rising edge.
- flash_data  in  32  DataOUT from controller.
- flash_data_valid  in  1  data_valid from controller; may stay high several clk cycles.
- flash_busy  in  1  controller busy.
- ram_addr  out  RAM_AW  RAM write address.
- ram_wdata  out  32  RAM write data.
- ram_we  out  1  single-cycle RAM write strobe.
- cpu_rst  out  1  CPU reset hold, active-high.
- boot_done  out  1  image loaded, CPU released.
- boot_error  out  1  timeout or checksum failure.
- reboot  in  1  single-cycle pulse; restarts the load, honoured only in DONE or ERROR.

## Operation
- Word index idx, width RAM_AW+1, counts 0..WORD_COUNT-1. Flash address is START_ADDR+idx, truncated to 16 bits (wraps modulo 2^16). ram_addr = idx[RAM_AW-1:0].
- States:
  - REQ: wait until flash_busy==0, then drive address, set flash_read_enable=1, go to WAIT_ACK.
  - WAIT_ACK: hold flash_read_enable=1 until flash_busy==1, then clear it and go to WAIT_DATA.
  - WAIT_DATA: on a rising edge of flash_data_valid (registered dv_q, detect dv & ~dv_q), capture flash_data and go to WRITE.
  - WRITE: ram_we=1 for exactly one cycle. If idx==WORD_COUNT-1, go to CHECK; else increment idx and go to REQ.
  - CHECK: go to DONE (checksum variant: see Configuration).
  - DONE: cpu_rst=0, boot_done=1.
  - ERROR: boot_error=1, cpu_rst=1, flash_read_enable=0.
- Timeout:
  - The counter clears on entry to WAIT_ACK and WAIT_DATA.
  - When it reaches TIMEOUT-1 in either state, go to ERROR.
- reboot in DONE or ERROR:
  - cpu_rst=1, boot_done=0, boot_error=0, idx=0, checksum=0; go to REQ.
  - reboot in any other state is ignored.
- Reset mid-operation: all state aborts immediately. The load restarts from START_ADDR after rst falls, with no partial-state carry-over.

## Timing
- Reset values: flash_adresse=START_ADDR, flash_read_enable=0, ram_addr=0, ram_wdata=0, ram_we=0, cpu_rst=1, boot_done=0, boot_error=0; state=REQ.
- First flash_read_enable rises no earlier than the first clk edge after rst deasserts, and only with flash_busy==0.
- flash_adresse is stable from REQ until exit from WAIT_DATA.
- ram_we asserts exactly one cycle after the valid edge is detected.
- DONE outputs (cpu_rst fall, boot_done rise) change 2 cycles after the last ram_we: WRITE→CHECK→DONE.
- A stale high data_valid left over from the previous word is not re-accepted, because rising-edge detection is required.
- All outputs are registered.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - 32-bit wrapping sum of words 0..WORD_COUNT-2 accumulates during WRITE.
  - In CHECK, the sum is compared with the final word, which is still written to RAM.
  - Equal → DONE; unequal → ERROR.
  - WORD_COUNT must be ≥ 2.
- BOOT_CHECKSUM_EN undefined: no accumulator; CHECK always goes to DONE; boot_error arises only from timeout.

## Structure
- Package flash_boot_pkg holds:
  - state encoding constants (REQ, WAIT_ACK, WAIT_DATA, WRITE, CHECK, DONE, ERROR);
  - WORD_W=32 and FLASH_AW=16.
- One sub-module, flash_boot_timer:
  - TIMEOUT-parameterised counter with clear and enable inputs;
  - produces an expired pulse.

## Test plan
- WORD_COUNT=4, START_ADDR=16'h0100, flash model returns 32'h11111111*(n+1):
  - four ram_we pulses, addr 0..3, with data 11111111, 22222222, 33333333, 44444444;
  - flash_adresse 0100..0103;
  - boot_done=1 and cpu_rst=0 two cycles after the last write.
- flash_busy held high 50 cycles after reset → flash_read_enable stays 0 until busy falls, then rises one cycle later.
- TIMEOUT=64, model never asserts data_valid → boot_error=1 and cpu_rst=1 after 64 cycles in WAIT_DATA; no ram_we.
- reboot pulse during WAIT_DATA is ignored. reboot in DONE gives cpu_rst=1, boot_done=0, then a full reload from START_ADDR.
- BOOT_CHECKSUM_EN, WORD_COUNT=4:
  - words 1,2,3,6 → DONE;
  - words 1,2,3,7 → ERROR with all four words written.
- rst asserted during the third word → outputs immediately at reset values; after release, the first read again uses START_ADDR.

Source files
------------

// File: rtl/flash_boot_pkg.sv
// flash_boot_pkg: shared widths and FSM state encoding for the flash boot loader.
package flash_boot_pkg;
    localparam int WORD_W   = 32;
    localparam int FLASH_AW = 16;
    typedef enum logic [2:0] {REQ, WAIT_ACK, WAIT_DATA, WRITE, CHECK, DONE, ERROR} state_e;
endpackage

// File: rtl/flash_boot_timer.sv
// flash_boot_timer: per-wait-state timeout counter; expired_o marks the last allowed cycle.
module flash_boot_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign cnt_d = clr_i ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    assign expired_o = en_i && cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/flash_boot_loader.sv
// flash_boot_loader: copies WORD_COUNT flash words into program RAM, then releases the CPU.
// Define BOOT_CHECKSUM_EN to require the last word to equal the wrapping sum of the others.
module flash_boot_loader import flash_boot_pkg::*; #(
    parameter int                  WORD_COUNT = 1024,
    parameter logic [FLASH_AW-1:0] START_ADDR = 16'h0000,
    parameter int                  RAM_AW     = 10,
    parameter int                  TIMEOUT    = 4096
) (
    input  logic                clk,
    input  logic                rst,
    output logic [FLASH_AW-1:0] flash_adresse,
    output logic                flash_read_enable,
    input  logic [WORD_W-1:0]   flash_data,
    input  logic                flash_data_valid,
    input  logic                flash_busy,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [WORD_W-1:0]   ram_wdata,
    output logic                ram_we,
    output logic                cpu_rst,
    output logic                boot_done,
    output logic                boot_error,
    input  logic                reboot
);
    localparam int IW = RAM_AW + 1;
    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [FLASH_AW-1:0] addr_q, addr_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                fre_q, fre_d, we_q, we_d, cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d, err_q, err_d, dv_q;
    logic                last, rb, dv_edge, expired, chk_ok;
    assign last    = idx_q == IW'(WORD_COUNT - 1);
    assign rb      = reboot && (state_q == DONE || state_q == ERROR);
    assign dv_edge = flash_data_valid && !dv_q;
    flash_boot_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_d != state_q),
        .en_i      (state_q == WAIT_ACK || state_q == WAIT_DATA),
        .expired_o (expired)
    );
`ifdef BOOT_CHECKSUM_EN
    logic [WORD_W-1:0] sum_q, sum_d;
    assign sum_d  = rb ? '0 : (state_q == WRITE && !last) ? sum_q + wdata_q : sum_q;
    assign chk_ok = sum_q == wdata_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
`else
    assign chk_ok = 1'b1;
`endif
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        addr_d     = addr_q;
        ram_addr_d = ram_addr_q;
        wdata_d    = wdata_q;
        fre_d      = fre_q;
        we_d       = 1'b0;
        cpu_rst_d  = cpu_rst_q;
        done_d     = done_q;
        err_d      = err_q;
        case (state_q)
            REQ: if (!flash_busy) begin
                fre_d   = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: if (flash_busy || expired) begin
                fre_d   = 1'b0;
                err_d   = !flash_busy;
                state_d = flash_busy ? WAIT_DATA : ERROR;
            end
            // data wins over a simultaneous expiry so a last-cycle word is not lost
            WAIT_DATA: if (dv_edge) begin
                wdata_d    = flash_data;
                ram_addr_d = idx_q[RAM_AW-1:0];
                we_d       = 1'b1;
                state_d    = WRITE;
            end else if (expired) begin
                err_d   = 1'b1;
                state_d = ERROR;
            end
            WRITE: begin
                idx_d   = last ? idx_q : idx_q + 1'b1;
                addr_d  = last ? addr_q : addr_q + 1'b1;
                state_d = last ? CHECK : REQ;
            end
            CHECK: begin
                cpu_rst_d = !chk_ok;
                done_d    = chk_ok;
                err_d     = !chk_ok;
                state_d   = chk_ok ? DONE : ERROR;
            end
            DONE, ERROR: if (rb) begin
                idx_d     = '0;
                addr_d    = START_ADDR;
                cpu_rst_d = 1'b1;
                done_d    = 1'b0;
                err_d     = 1'b0;
                state_d   = REQ;
            end
            default: state_d = ERROR;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q    <= REQ;
            idx_q      <= '0;
            addr_q     <= START_ADDR;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            fre_q      <= 1'b0;
            we_q       <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dv_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            addr_q     <= addr_d;
            ram_addr_q <= ram_addr_d;
            wdata_q    <= wdata_d;
            fre_q      <= fre_d;
            we_q       <= we_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
            dv_q       <= flash_data_valid;
        end
    assign flash_adresse     = addr_q;
    assign flash_read_enable = fre_q;
    assign ram_addr          = ram_addr_q;
    assign ram_wdata         = wdata_q;
    assign ram_we            = we_q;
    assign cpu_rst           = cpu_rst_q;
    assign boot_done         = done_q;
    assign boot_error        = err_q;
endmodule

// File: tb/tb_flash_boot_loader.sv
// tb_flash_boot_loader: directed checks of the boot copier against a simple flash controller model.
module tb_flash_boot_loader;
    import flash_boot_pkg::*;
    logic        clk = 1'b0;
    logic        rst, reboot, busy_m, hold_busy, drop_valid;
    logic        flash_busy, flash_data_valid, flash_read_enable;
    logic [31:0] flash_data, ram_wdata;
    logic [15:0] flash_adresse;
    logic [9:0]  ram_addr;
    logic        ram_we, cpu_rst, boot_done, boot_error;
    logic [31:0] words [4];
    logic [15:0] a;
    logic [9:0]  wq_addr [$];
    logic [31:0] wq_data [$];
    logic [15:0] wq_fa [$], rq [$];
    logic        fre_p = 0, done_p = 0, err_p = 0, busy_p = 0, bad;
    int          cyc = 0, last_we_cyc = 0, done_cyc = 0, err_cyc = 0, busy_cyc = 0;
    int          n_chk = 0, n_fail = 0, n;
    logic        exp_bad;

    assign flash_busy = busy_m | hold_busy;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    flash_boot_loader #(.WORD_COUNT(4), .START_ADDR(16'h0100), .RAM_AW(10), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .flash_adresse(flash_adresse), .flash_read_enable(flash_read_enable),
        .flash_data(flash_data), .flash_data_valid(flash_data_valid), .flash_busy(flash_busy),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .cpu_rst(cpu_rst),
        .boot_done(boot_done), .boot_error(boot_error), .reboot(reboot)
    );

    // flash controller: ack with busy one cycle after the request, then a 3-cycle valid
    initial begin
        busy_m = 0; flash_data_valid = 0; flash_data = '0;
        forever begin
            @(negedge clk);
            if (flash_read_enable) begin
                a = flash_adresse;
                @(negedge clk); busy_m = 1;
                repeat (2) @(negedge clk);
                busy_m = 0;
                if (!drop_valid) begin flash_data = words[a[1:0]]; flash_data_valid = 1; end
                repeat (3) @(negedge clk);
                flash_data_valid = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (ram_we) begin
            wq_addr.push_back(ram_addr); wq_data.push_back(ram_wdata); wq_fa.push_back(flash_adresse);
            last_we_cyc = cyc;
        end
        if (flash_read_enable && !fre_p) rq.push_back(flash_adresse);
        if (boot_done && !done_p) done_cyc = cyc;
        if (boot_error && !err_p) err_cyc = cyc;
        if (flash_busy && !busy_p) busy_cyc = cyc;
        fre_p = flash_read_enable; done_p = boot_done; err_p = boot_error; busy_p = flash_busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        wq_addr.delete(); wq_data.delete(); wq_fa.delete(); rq.delete();
    endtask

    task automatic pulse_reboot();
        @(negedge clk); reboot = 1;
        @(negedge clk); reboot = 0;
    endtask

    task automatic wait_end(input string tag);
        int k = 0;
        while (!(boot_done || boot_error) && k < 2000) begin @(negedge clk); k++; end
        check({tag, "_finished"}, 32'(boot_done | boot_error), 1);
        @(negedge clk);
    endtask

    task automatic check_load(input string tag);
        check({tag, "_nwrites"}, wq_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wq_addr[i]), i);
            check($sformatf("%s_data%0d", tag, i), wq_data[i], words[i]);
            check($sformatf("%s_flash%0d", tag, i), 32'(wq_fa[i]), 32'h0100 + i);
        end
    endtask

    initial begin
        rst = 1; reboot = 0; hold_busy = 1; drop_valid = 0;
        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        repeat (3) @(negedge clk);
        check("rst_flash_addr", 32'(flash_adresse), 32'h0100);
        check("rst_fre", 32'(flash_read_enable), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_wdata", ram_wdata, 0);
        check("rst_we", 32'(ram_we), 0);
        check("rst_cpu_rst", 32'(cpu_rst), 1);
        check("rst_done", 32'(boot_done), 0);
        check("rst_err", 32'(boot_error), 0);
        rst = 0;
        bad = 0;
        repeat (50) begin @(negedge clk); if (flash_read_enable) bad = 1; end
        check("fre_held_by_busy", 32'(bad), 0);
        hold_busy = 0;
        @(posedge clk); #1;
        check("fre_after_busy", 32'(flash_read_enable), 1);
        check("fre_first_addr", 32'(flash_adresse), 32'h0100);
        wait_end("load1");
        check_load("load1");
        check("load1_done", 32'(boot_done), 1);
        check("load1_cpu_rst", 32'(cpu_rst), 0);
        check("load1_err", 32'(boot_error), 0);
        check("load1_done_latency", done_cyc - last_we_cyc, 2);

        clear_q();
        pulse_reboot();
        check("reboot_cpu_rst", 32'(cpu_rst), 1);
        check("reboot_done", 32'(boot_done), 0);
        n = 0;
        while (dut.state_q != WAIT_DATA && n < 200) begin @(negedge clk); n++; end
        check("reach_wait_data", 32'(n < 200), 1);
        pulse_reboot();
        wait_end("reload");
        check_load("reload");
        check("reload_nreq", rq.size(), 4);
        check("reload_first_req", 32'(rq[0]), 32'h0100);
        check("reload_done", 32'(boot_done), 1);

        words = '{32'd1, 32'd2, 32'd3, 32'd6};
        clear_q(); pulse_reboot(); wait_end("sum_ok");
        check_load("sum_ok");
        check("sum_ok_done", 32'(boot_done), 1);
        check("sum_ok_err", 32'(boot_error), 0);

`ifdef BOOT_CHECKSUM_EN
        exp_bad = 1;
`else
        exp_bad = 0;
`endif
        words = '{32'd1, 32'd2, 32'd3, 32'd7};
        clear_q(); pulse_reboot(); wait_end("sum_bad");
        check_load("sum_bad");
        check("sum_bad_err", 32'(boot_error), 32'(exp_bad));
        check("sum_bad_done", 32'(boot_done), 32'(!exp_bad));
        check("sum_bad_cpu_rst", 32'(cpu_rst), 32'(exp_bad));

        words = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        clear_q(); pulse_reboot();
        n = 0;
        while (wq_data.size() < 2 && n < 500) begin @(negedge clk); n++; end
        check("mid_two_writes", wq_data.size(), 2);
        repeat (3) @(negedge clk);
        rst = 1; #1;
        check("mid_rst_fre", 32'(flash_read_enable), 0);
        check("mid_rst_addr", 32'(flash_adresse), 32'h0100);
        check("mid_rst_we", 32'(ram_we), 0);
        check("mid_rst_ram_addr", 32'(ram_addr), 0);
        check("mid_rst_wdata", ram_wdata, 0);
        check("mid_rst_cpu_rst", 32'(cpu_rst), 1);
        check("mid_rst_done", 32'(boot_done), 0);
        check("mid_rst_err", 32'(boot_error), 0);
        repeat (12) @(negedge clk);
        clear_q();
        rst = 0;
        wait_end("after_rst");
        check("after_rst_first_req", 32'(rq[0]), 32'h0100);
        check_load("after_rst");
        check("after_rst_done", 32'(boot_done), 1);

        drop_valid = 1;
        clear_q(); pulse_reboot(); wait_end("timeout");
        check("timeout_err", 32'(boot_error), 1);
        check("timeout_cpu_rst", 32'(cpu_rst), 1);
        check("timeout_done", 32'(boot_done), 0);
        check("timeout_fre", 32'(flash_read_enable), 0);
        check("timeout_nwrites", wq_data.size(), 0);
        check("timeout_cycles", err_cyc - busy_cyc, 64);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
